// File: rtl/vend_pkg.sv
// Shared types for the coffee vending coin path: coin codes, scheduler
// states and the coin-to-strobe mapping used by the coin scheduler.
package vend_pkg;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        C50  = 2'b01,
        C100 = 2'b10,
        C200 = 2'b11
    } coin_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_PULSE = 2'b01,
        S_GAP   = 2'b10
    } sched_state_t;

    // Bit 0 drives r50, bit 1 r100, bit 2 r200; NONE maps to no strobe.
    function automatic logic [2:0] coin_to_onehot(input coin_t c);
        logic [2:0] oh;
        case (c)
            C50:     oh = 3'b001;
            C100:    oh = 3'b010;
            C200:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/coin_fifo.sv
// Coin queue: DEPTH entries of coin_t, up to three ordered pushes and one
// pop per cycle. Pushes that do not fit are discarded from the highest
// index down and reported on 'dropped' in the same cycle.
module coin_fifo
    import vend_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [2:0]                   push_vld,
    input  coin_t                        push_code [3],
    input  logic                         pop,
    output coin_t                        head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         dropped
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    coin_t          mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  waddr [3];
    logic [2:0]     wen;
    logic [1:0]     n_push;
    logic [CW:0]    free;
    logic [CW-1:0]  count_n;

    // Pack accepted pushes into consecutive slots; a slot freed by this
    // cycle's pop is already usable.
    always_comb begin
        free    = (CW+1)'(DEPTH) - {1'b0, count} + {{CW{1'b0}}, pop};
        n_push  = '0;
        wen     = '0;
        dropped = 1'b0;
        for (int i = 0; i < 3; i++) begin
            waddr[i] = wr_ptr + PW'(n_push);
            if (push_vld[i]) begin
                if ((CW+1)'(n_push) < free) begin
                    wen[i] = 1'b1;
                    n_push = n_push + 2'd1;
                end else begin
                    dropped = 1'b1;
                end
            end
        end
        count_n = count + CW'(n_push) - CW'(pop);
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + PW'(n_push);
            rd_ptr <= rd_ptr + PW'(pop);
            count  <= count_n;
            full   <= (count_n == CW'(DEPTH));
        end
    end

    // Storage is data only and needs no reset; occupancy guards every read.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (wen[i]) begin
                mem[waddr[i]] <= push_code[i];
            end
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/coin_scheduler.sv
// Coin scheduler: edge-detects the three coin sensors, queues coins and
// feeds the vending FSM one single-cycle coin strobe at a time, each
// followed by GAP idle cycles, never starting a strobe while hold is high.
module coin_scheduler
    import vend_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int GAP   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         s50,
    input  logic                         s100,
    input  logic                         s200,
    input  logic                         hold,
    output logic                         r50,
    output logic                         r100,
    output logic                         r200,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         rej,
    output logic                         overflow
);

    localparam int GW = $clog2(GAP + 1);

    logic [2:0]     sens;
    logic [2:0]     sens_q;
    logic [2:0]     ev;
    coin_t          push_code [3];
    coin_t          head;
    logic           dropped;
    logic           pop;

    sched_state_t   state;
    sched_state_t   state_n;
    logic [GW-1:0]  gcnt;
    logic [GW-1:0]  gcnt_n;
    logic [2:0]     r_q;
    logic [2:0]     r_n;

    assign sens = {s200, s100, s50};
    assign ev   = sens & ~sens_q;

    assign push_code[0] = C50;
    assign push_code[1] = C100;
    assign push_code[2] = C200;

    // Sensor history; loading it during reset too means a sensor held
    // through reset does not register as a new coin afterwards.
    always_ff @(posedge clk) begin
        sens_q <= sens;
    end

    coin_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_vld  (ev),
        .push_code (push_code),
        .pop       (pop),
        .head      (head),
        .count     (count),
        .full      (full),
        .dropped   (dropped)
    );

    // Drop reporting: one-cycle rej plus a sticky overflow flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rej      <= 1'b0;
            overflow <= 1'b0;
        end else begin
            rej      <= dropped;
            overflow <= overflow | dropped;
        end
    end

    // State register, gap counter and registered coin strobes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
            gcnt  <= '0;
            r_q   <= '0;
        end else begin
            state <= state_n;
            gcnt  <= gcnt_n;
            r_q   <= r_n;
        end
    end

    // Next-state: hold only gates the start of a delivery, never a pulse or gap in flight.
    always_comb begin
        state_n = state;
        gcnt_n  = gcnt;
        case (state)
            S_IDLE: begin
                if ((count != '0) && !hold) begin
                    state_n = S_PULSE;
                end
            end
            S_PULSE: begin
                state_n = S_GAP;
                gcnt_n  = GW'(GAP);
            end
            S_GAP: begin
                if (gcnt <= GW'(1)) begin
                    state_n = S_IDLE;
                    gcnt_n  = '0;
                end else begin
                    gcnt_n  = gcnt - GW'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
                gcnt_n  = '0;
            end
        endcase
    end

    // Outputs: strobe is prepared on entry to PULSE, head is popped while in PULSE.
    always_comb begin
        pop = (state == S_PULSE);
        r_n = '0;
        if ((state == S_IDLE) && (state_n == S_PULSE)) begin
            r_n = coin_to_onehot(head);
        end
    end

    assign r50  = r_q[0];
    assign r100 = r_q[1];
    assign r200 = r_q[2];

endmodule

// File: tb/tb_coin_scheduler.sv
// Bench for coin_scheduler: directed scenarios followed by random sensor,
// hold and reset activity, all compared cycle by cycle against a queue and
// timestamp based model of coin acceptance and delivery.
module tb_coin_scheduler;

    localparam int DEPTH = 4;
    localparam int GAP   = 1;

    logic       clk  = 1'b0;
    logic       rst  = 1'b0;
    logic       s50  = 1'b0;
    logic       s100 = 1'b0;
    logic       s200 = 1'b0;
    logic       hold = 1'b0;
    logic       r50, r100, r200;
    logic [2:0] count;
    logic       full, rej, overflow;

    coin_scheduler #(
        .DEPTH (DEPTH),
        .GAP   (GAP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .s50      (s50),
        .s100     (s100),
        .s200     (s200),
        .hold     (hold),
        .r50      (r50),
        .r100     (r100),
        .r200     (r200),
        .count    (count),
        .full     (full),
        .rej      (rej),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Model: queued coin codes (1=50, 2=100, 3=200), expected registered
    // outputs for the current cycle, and the earliest cycle at which a new
    // delivery may be decided.
    int         q[$];
    logic [2:0] exp_r   = '0;
    logic [2:0] prev_s  = '0;
    int         exp_cnt = 0;
    logic       exp_full = 1'b0;
    logic       exp_rej  = 1'b0;
    logic       exp_ovf  = 1'b0;
    int         cyc     = 0;
    int         ready   = 0;
    bit         mvalid  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: compare at the falling edge, advance the model with
    // the inputs the DUT will sample at the next rising edge.
    task automatic step();
        logic [2:0] sv;
        logic [2:0] ev;
        logic [2:0] nr;
        logic       drop;
        @(negedge clk);
        if (mvalid) begin
            chk("r",        {29'd0, r200, r100, r50}, {29'd0, exp_r});
            chk("count",    {29'd0, count},           exp_cnt);
            chk("full",     {31'd0, full},            {31'd0, exp_full});
            chk("rej",      {31'd0, rej},             {31'd0, exp_rej});
            chk("overflow", {31'd0, overflow},        {31'd0, exp_ovf});
        end
        sv = {s200, s100, s50};
        ev = sv & ~prev_s;
        if (!rst) begin
            q.delete();
            exp_r    = '0;
            exp_cnt  = 0;
            exp_full = 1'b0;
            exp_rej  = 1'b0;
            exp_ovf  = 1'b0;
            ready    = cyc + 1;
            mvalid   = 1'b1;
        end else begin
            nr = '0;
            if (cyc >= ready && q.size() > 0 && !hold) begin
                nr    = 3'b001 << (q[0] - 1);
                ready = cyc + 2 + GAP;
            end
            if (exp_r != 0) void'(q.pop_front());
            drop = 1'b0;
            for (int i = 0; i < 3; i++) begin
                if (ev[i]) begin
                    if (q.size() < DEPTH) q.push_back(i + 1);
                    else drop = 1'b1;
                end
            end
            exp_rej  = drop;
            exp_ovf  = exp_ovf | drop;
            exp_cnt  = q.size();
            exp_full = (q.size() == DEPTH);
            exp_r    = nr;
        end
        prev_s = sv;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Sensor held high through reset must not produce a coin.
        rst  = 1'b0;
        s100 = 1'b1;
        repeat (3) step();
        rst = 1'b1;
        repeat (5) step();
        chk("t1_count", {29'd0, count}, 0);
        s100 = 1'b0;
        step();

        // Single 0.50 coin.
        s50 = 1'b1;
        repeat (2) step();
        s50 = 1'b0;
        repeat (6) step();

        // All three sensors rise together, briefly held off.
        {s200, s100, s50} = 3'b111;
        hold = 1'b1;
        step();
        {s200, s100, s50} = 3'b000;
        step();
        hold = 1'b0;
        repeat (12) step();

        // Two coins arrive during a long hold.
        hold = 1'b1;
        s50 = 1'b1; step();
        s50 = 1'b0; step();
        s50 = 1'b1; step();
        s50 = 1'b0;
        repeat (17) step();
        chk("t4_count", {29'd0, count}, 2);
        hold = 1'b0;
        repeat (10) step();

        // Three queued, then all three sensors rise with one free slot.
        hold = 1'b1;
        s50  = 1'b1; step();
        s50  = 1'b0; step();
        s100 = 1'b1; step();
        s100 = 1'b0; step();
        s200 = 1'b1; step();
        s200 = 1'b0; step();
        {s200, s100, s50} = 3'b111;
        step();
        {s200, s100, s50} = 3'b000;
        repeat (3) step();
        chk("t5_overflow", {31'd0, overflow}, 1);
        chk("t5_full",     {31'd0, full},     1);
        hold = 1'b0;
        repeat (16) step();

        // Reset in the middle of a pulse with two coins queued.
        hold = 1'b1;
        s50  = 1'b1; step();
        s50  = 1'b0; step();
        s100 = 1'b1; step();
        s100 = 1'b0; step();
        hold = 1'b0;
        for (int i = 0; i < 10 && exp_r == 0; i++) step();
        chk("t6_pulse_seen", {29'd0, exp_r}, {29'd0, 3'b001});
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("t6_count", {29'd0, count},  0);
        chk("t6_r",     {29'd0, r200, r100, r50}, 0);
        repeat (10) step();

        // Random sensors, hold and occasional reset.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(2, 0) == 0) s50  = ~s50;
            if ($urandom_range(2, 0) == 0) s100 = ~s100;
            if ($urandom_range(2, 0) == 0) s200 = ~s200;
            if ($urandom_range(7, 0) == 0) hold = ~hold;
            rst = ($urandom_range(99, 0) != 0);
            step();
        end
        rst = 1'b1;
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
